// File: rtl/bistable_pkg.sv
// rtl/bistable_pkg.sv - shared encodings and reset values for the bistable cell bank
// Purpose: JK/SR input encodings and the reset values used by every lane.
// Ports: none (package).
package bistable_pkg;

  // JK input encodings, applied to {j,k}
  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  // SR input encodings, applied to {s,r}
  localparam logic [1:0] SR_HOLD    = 2'b00;
  localparam logic [1:0] SR_RESET   = 2'b01;
  localparam logic [1:0] SR_SET     = 2'b10;
  localparam logic [1:0] SR_INVALID = 2'b11;

  // Reset values for true output, complement output and invalid flag
  localparam logic RST_Q   = 1'b0;
  localparam logic RST_QN  = 1'b1;
  localparam logic RST_ERR = 1'b0;

endpackage

// File: rtl/bistable_lane.sv
// rtl/bistable_lane.sv - one bit of D, JK and SR storage plus the SR invalid flag
// Purpose: single lane of the bistable bank; all outputs come straight from flops.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   en             update enable (tie high when unused)
//   d              D input
//   j, k           JK inputs
//   s, r           SR inputs
//   d_q, d_qn      D state and complement
//   jk_q, jk_qn    JK state and complement
//   sr_q, sr_qn    SR state and complement (both 0 after s=r=1)
//   sr_err         set for one cycle after an edge that sampled s=r=1
module bistable_lane
  import bistable_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  input  logic j,
  input  logic k,
  input  logic s,
  input  logic r,
  output logic d_q,
  output logic d_qn,
  output logic jk_q,
  output logic jk_qn,
  output logic sr_q,
  output logic sr_qn,
  output logic sr_err
);

  logic jk_next;
  logic sr_q_next;
  logic sr_qn_next;
  logic sr_err_next;

  always_comb begin
    jk_next = jk_q;
    case ({j, k})
      JK_HOLD:   jk_next = jk_q;
      JK_RESET:  jk_next = 1'b0;
      JK_SET:    jk_next = 1'b1;
      JK_TOGGLE: jk_next = ~jk_q;
      default:   jk_next = jk_q;
    endcase
  end

  always_comb begin
    sr_q_next   = sr_q;
    sr_qn_next  = sr_qn;
    sr_err_next = 1'b0;
    case ({s, r})
      // Hold keeps q; qn is rebuilt from q so that leaving the invalid state
      // (q=qn=0) resolves reset-dominant to qn=1.
      SR_HOLD: begin
        sr_q_next  = sr_q;
        sr_qn_next = ~sr_q;
      end
      SR_RESET: begin
        sr_q_next  = 1'b0;
        sr_qn_next = 1'b1;
      end
      SR_SET: begin
        sr_q_next  = 1'b1;
        sr_qn_next = 1'b0;
      end
      SR_INVALID: begin
        // NOR-latch behaviour: both outputs pulled low
        sr_q_next   = 1'b0;
        sr_qn_next  = 1'b0;
        sr_err_next = 1'b1;
      end
      default: begin
        sr_q_next  = sr_q;
        sr_qn_next = sr_qn;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q    <= RST_Q;
      d_qn   <= RST_QN;
      jk_q   <= RST_Q;
      jk_qn  <= RST_QN;
      sr_q   <= RST_Q;
      sr_qn  <= RST_QN;
      sr_err <= RST_ERR;
    end else if (en) begin
      d_q    <= d;
      d_qn   <= ~d;
      jk_q   <= jk_next;
      jk_qn  <= ~jk_next;
      sr_q   <= sr_q_next;
      sr_qn  <= sr_qn_next;
      sr_err <= sr_err_next;
    end
  end

endmodule

// File: rtl/bistable_cell_bank.sv
// rtl/bistable_cell_bank.sv - WIDTH independent lanes of D, JK and SR storage
// Purpose: bank of clocked bistable lanes; every output is registered, latency 1 clk.
// Optional feature: define BISTABLE_ENABLE_EN to add the en input (en=0 holds every lane).
// Ports:
//   clk, rst         clock and synchronous active-high reset (reset beats en)
//   d, j, k, s, r    per-lane inputs, WIDTH bits each
//   en               update enable (only with BISTABLE_ENABLE_EN)
//   d_q/d_qn, jk_q/jk_qn, sr_q/sr_qn, sr_err   per-lane registered outputs
module bistable_cell_bank
  import bistable_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
`ifdef BISTABLE_ENABLE_EN
  input  logic             en,
`endif
  output logic [WIDTH-1:0] d_q,
  output logic [WIDTH-1:0] d_qn,
  output logic [WIDTH-1:0] jk_q,
  output logic [WIDTH-1:0] jk_qn,
  output logic [WIDTH-1:0] sr_q,
  output logic [WIDTH-1:0] sr_qn,
  output logic [WIDTH-1:0] sr_err
);

  logic lane_en;

`ifdef BISTABLE_ENABLE_EN
  assign lane_en = en;
`else
  assign lane_en = 1'b1;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    bistable_lane u_lane (
      .clk    (clk),
      .rst    (rst),
      .en     (lane_en),
      .d      (d[i]),
      .j      (j[i]),
      .k      (k[i]),
      .s      (s[i]),
      .r      (r[i]),
      .d_q    (d_q[i]),
      .d_qn   (d_qn[i]),
      .jk_q   (jk_q[i]),
      .jk_qn  (jk_qn[i]),
      .sr_q   (sr_q[i]),
      .sr_qn  (sr_qn[i]),
      .sr_err (sr_err[i])
    );
  end

endmodule

// File: tb/tb_bistable_cell_bank.sv
// tb/tb_bistable_cell_bank.sv - self-checking bench for bistable_cell_bank
// Purpose: table-driven lane sequences, reset checks and a randomized run against a reference model.
// Ports: none (top-level bench).
module tb_bistable_cell_bank;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] d, j, k, s, r;
  logic         en;
  logic [W-1:0] d_q, d_qn, jk_q, jk_qn, sr_q, sr_qn, sr_err;

  always #5 clk = ~clk;

  bistable_cell_bank #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .d      (d),
    .j      (j),
    .k      (k),
    .s      (s),
    .r      (r),
`ifdef BISTABLE_ENABLE_EN
    .en     (en),
`endif
    .d_q    (d_q),
    .d_qn   (d_qn),
    .jk_q   (jk_q),
    .jk_qn  (jk_qn),
    .sr_q   (sr_q),
    .sr_qn  (sr_qn),
    .sr_err (sr_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state, one entry per lane
  bit m_d   [W];
  bit m_jk  [W];
  bit m_sq  [W];
  bit m_sqn [W];
  bit m_err [W];

  typedef struct {
    logic rst, d, j, k, s, r;
    logic e_d, e_jk, e_sq, e_sqn, e_err;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < W; i++) begin
      m_d[i] = 0; m_jk[i] = 0; m_sq[i] = 0; m_sqn[i] = 1; m_err[i] = 0;
    end
  endtask

  // Applies the lane rules to the current inputs, as the next edge will.
  task automatic model_edge();
    if (rst) begin
      model_reset();
      return;
    end
    if (!en) return;
    for (int i = 0; i < W; i++) begin
      bit was_invalid;
      was_invalid = m_err[i];
      m_d[i] = d[i];
      if (j[i] && k[i])      m_jk[i] = !m_jk[i];
      else if (j[i])         m_jk[i] = 1;
      else if (k[i])         m_jk[i] = 0;
      if (s[i] && r[i]) begin
        m_sq[i] = 0; m_sqn[i] = 0; m_err[i] = 1;
      end else if (s[i]) begin
        m_sq[i] = 1; m_sqn[i] = 0; m_err[i] = 0;
      end else if (r[i]) begin
        m_sq[i] = 0; m_sqn[i] = 1; m_err[i] = 0;
      end else begin
        if (was_invalid) m_sqn[i] = 1;
        m_err[i] = 0;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [W-1:0] ed, ejk, esq, esqn, eerr;
    for (int i = 0; i < W; i++) begin
      ed[i] = m_d[i]; ejk[i] = m_jk[i]; esq[i] = m_sq[i];
      esqn[i] = m_sqn[i]; eerr[i] = m_err[i];
    end
    chk({tag, " d_q"},    d_q,    ed);
    chk({tag, " d_qn"},   d_qn,   ~ed);
    chk({tag, " jk_q"},   jk_q,   ejk);
    chk({tag, " jk_qn"},  jk_qn,  ~ejk);
    chk({tag, " sr_q"},   sr_q,   esq);
    chk({tag, " sr_qn"},  sr_qn,  esqn);
    chk({tag, " sr_err"}, sr_err, eerr);
  endtask

  initial begin
    //             rst d j k s r   d jk sq sqn err
    tbl[0]  = '{0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 1};
    tbl[1]  = '{0, 1, 0, 0, 0, 0,  1, 0, 0, 1, 0};
    tbl[2]  = '{0, 1, 0, 1, 1, 0,  1, 0, 1, 0, 0};
    tbl[3]  = '{0, 0, 0, 1, 0, 0,  0, 0, 1, 0, 0};
    tbl[4]  = '{0, 0, 1, 0, 0, 1,  0, 1, 0, 1, 0};
    tbl[5]  = '{0, 1, 1, 0, 0, 0,  1, 1, 0, 1, 0};
    tbl[6]  = '{0, 0, 1, 1, 1, 1,  0, 0, 0, 0, 1};
    tbl[7]  = '{0, 0, 1, 1, 1, 0,  0, 1, 1, 0, 0};
    tbl[8]  = '{0, 1, 1, 1, 1, 1,  1, 0, 0, 0, 1};
    tbl[9]  = '{0, 1, 1, 1, 0, 1,  1, 1, 0, 1, 0};
    tbl[10] = '{1, 1, 1, 1, 1, 0,  0, 0, 0, 1, 0};
    tbl[11] = '{0, 0, 1, 1, 0, 0,  0, 1, 0, 1, 0};
    tbl[12] = '{0, 0, 1, 1, 0, 0,  0, 0, 0, 1, 0};

    en = 1'b1;

    // Reset for two edges with random data on every input
    rst = 1'b1;
    for (int n = 0; n < 2; n++) begin
      d = W'($urandom); j = W'($urandom); k = W'($urandom);
      s = W'($urandom); r = W'($urandom);
      tick();
      model_reset();
      check_model("reset");
    end

    // Directed lane sequences, replicated across all lanes
    for (int i = 0; i < 13; i++) begin
      rst = tbl[i].rst;
      d = {W{tbl[i].d}}; j = {W{tbl[i].j}}; k = {W{tbl[i].k}};
      s = {W{tbl[i].s}}; r = {W{tbl[i].r}};
      tick();
      chk($sformatf("tbl%0d d_q", i),    d_q,    {W{tbl[i].e_d}});
      chk($sformatf("tbl%0d d_qn", i),   d_qn,   ~{W{tbl[i].e_d}});
      chk($sformatf("tbl%0d jk_q", i),   jk_q,   {W{tbl[i].e_jk}});
      chk($sformatf("tbl%0d jk_qn", i),  jk_qn,  ~{W{tbl[i].e_jk}});
      chk($sformatf("tbl%0d sr_q", i),   sr_q,   {W{tbl[i].e_sq}});
      chk($sformatf("tbl%0d sr_qn", i),  sr_qn,  {W{tbl[i].e_sqn}});
      chk($sformatf("tbl%0d sr_err", i), sr_err, {W{tbl[i].e_err}});
    end

    // Reset mid-toggle at q=1, then toggling resumes from 0
    rst = 1'b0; j = '1; k = '0; s = '0; r = '0; d = '0;
    tick();
    chk("pre-rst jk_q", jk_q, '1);
    rst = 1'b1; j = '1; k = '1;
    tick();
    chk("rst jk_q", jk_q, '0);
    rst = 1'b0;
    tick();
    chk("resume jk_q 1", jk_q, '1);
    tick();
    chk("resume jk_q 0", jk_q, '0);

    // Randomized run against the reference model, lanes driven independently
    rst = 1'b1;
    tick();
    model_reset();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 19) == 0);
      d = W'($urandom); j = W'($urandom); k = W'($urandom);
      s = W'($urandom); r = W'($urandom);
`ifdef BISTABLE_ENABLE_EN
      en = ($urandom_range(0, 3) != 0);
`endif
      model_edge();
      tick();
      check_model($sformatf("rand%0d", n));
    end

`ifdef BISTABLE_ENABLE_EN
    // en=0 holds everything, reset still wins, en=1 updates
    rst = 1'b1; en = 1'b1;
    tick();
    rst = 1'b0; en = 1'b0; d = '1; j = '1; k = '0; s = '1; r = '1;
    tick();
    chk("en0 d_q", d_q, '0);
    chk("en0 jk_q", jk_q, '0);
    chk("en0 sr_err", sr_err, '0);
    en = 1'b1;
    tick();
    chk("en1 d_q", d_q, '1);
    chk("en1 jk_q", jk_q, '1);
    chk("en1 sr_err", sr_err, '1);
    en = 1'b0; s = '0; r = '0;
    tick();
    chk("en0 hold sr_err", sr_err, '1);
    rst = 1'b1;
    tick();
    chk("rst over en d_q", d_q, '0);
    chk("rst over en sr_err", sr_err, '0);
    rst = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
